// File: rtl/yibi_fifo.sv
// Single-clock FIFO with pointer-derived status, registered read data and
// one-cycle overflow/underflow pulses. Storage is an unreset array for BRAM inference.
module yibi_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16384,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_full,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic [DATA_W-1:0] r_dout;
  logic              r_full;
  logic              r_empty;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_wptr_next;
  logic [ADDR_W:0]   w_rptr_next;
  logic              w_full_next;
  logic              w_empty_next;
  logic [ADDR_W:0]   w_count_next;

  // Acceptance uses the flags as they stood before the edge, so a
  // simultaneous write into an empty FIFO is never bypassed to dout.
  assign w_wr_acc = i_wr_en & ~r_full;
  assign w_rd_acc = i_rd_en & ~r_empty;

  assign w_wptr_next  = r_wptr + (ADDR_W+1)'(w_wr_acc);
  assign w_rptr_next  = r_rptr + (ADDR_W+1)'(w_rd_acc);
  assign w_empty_next = (w_wptr_next == w_rptr_next);
  assign w_full_next  = (w_wptr_next[ADDR_W-1:0] == w_rptr_next[ADDR_W-1:0]) &&
                        (w_wptr_next[ADDR_W] != w_rptr_next[ADDR_W]);
  assign w_count_next = w_wptr_next - w_rptr_next;

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      r_full      <= w_full_next;
      r_empty     <= w_empty_next;
      r_count     <= w_count_next;
      r_overflow  <= i_wr_en & r_full;
      r_underflow <= i_rd_en & r_empty;
    end
  end

  // Read register sits beside the array; it holds when no read is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout <= '0;
    end else if (w_rd_acc) begin
      r_dout <= r_mem[r_rptr[ADDR_W-1:0]];
    end
  end

  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_count     = r_count;
  assign o_dout      = r_dout;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_yibi_fifo.sv
// Bench for yibi_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_yibi_fifo;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              full, empty, overflow, underflow;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W:0]   count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  yibi_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_din(din), .o_full(full),
    .i_rd_en(rd_en), .o_dout(dout), .o_empty(empty), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the registered outputs.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      int sz;
      sz    = m_q.size();
      m_ovf = wr_en && (sz == DEPTH);
      m_unf = rd_en && (sz == 0);
      if (rd_en && sz > 0) m_dout = m_q.pop_front();
      if (wr_en && sz < DEPTH) m_q.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_dout",  32'(dout),      32'(m_dout));
      chk("model_count", 32'(count),     32'(m_q.size()));
      chk("model_empty", 32'(empty),     32'(m_q.size() == 0));
      chk("model_full",  32'(full),      32'(m_q.size() == DEPTH));
      chk("model_ovf",   32'(overflow),  32'(m_ovf));
      chk("model_unf",   32'(underflow), 32'(m_unf));
    end
  end

  // Drive one cycle starting from a negedge; returns at the next negedge.
  task automatic cyc(input bit w, input bit r, input logic [DATA_W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b1, '0);
  endtask

  initial begin
    logic [DATA_W-1:0] saved;
    int pw, pr;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Burst write 0..19, idle, burst read
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, DATA_W'(i));
    repeat (10) cyc(1'b0, 1'b0, '0);
    chk("burst_count", 32'(count), 32'd20);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("burst_dout", 32'(dout), 32'(i));
    end
    chk("burst_empty", 32'(empty), 32'd1);

    // Fill to full, overflow attempt, read back
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DATA_W'(16'h1000 + i));
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    cyc(1'b1, 1'b0, 16'hDEAD);
    chk("fill_ovf",   32'(overflow), 32'd1);
    chk("fill_count2", 32'(count),   32'(DEPTH));
    cyc(1'b0, 1'b0, '0);
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, '0);
      chk("fill_dout", 32'(dout), 32'(16'h1000 + i));
    end

    // Underflow while empty
    saved = dout;
    cyc(1'b0, 1'b1, '0);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_dout",  32'(dout),      32'(saved));
    chk("unf_count", 32'(count),     32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("unf_pulse_end", 32'(underflow), 32'd0);

    // Simultaneous access at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, DATA_W'(16'h2000 + i));
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, DATA_W'(16'h3000 + i));
    chk("sim5_count", 32'(count), 32'd5);
    chk("sim5_dout",  32'(dout),  32'(16'h3000 + 94));

    // Simultaneous at full: read only
    for (int i = 0; i < DEPTH - 5; i++) cyc(1'b1, 1'b0, DATA_W'($urandom));
    chk("simf_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b1, 16'hBEEF);
    chk("simf_count", 32'(count),    32'(DEPTH - 1));
    chk("simf_ovf",   32'(overflow), 32'd1);

    // Simultaneous at empty: write only, no bypass
    drain();
    saved = dout;
    cyc(1'b1, 1'b1, 16'h5A5A);
    chk("sime_count", 32'(count),     32'd1);
    chk("sime_unf",   32'(underflow), 32'd1);
    chk("sime_dout",  32'(dout),      32'(saved));
    cyc(1'b0, 1'b1, '0);
    chk("sime_read",  32'(dout),      32'h5A5A);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, DATA_W'(16'h0100 + i));
    cyc(1'b0, 1'b1, '0);
    chk("pre_rst_dout", 32'(dout), 32'h0100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout",  32'(dout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 16'hA5A5);
    cyc(1'b0, 1'b1, '0);
    chk("post_rst_dout",  32'(dout),  32'hA5A5);
    chk("post_rst_empty", 32'(empty), 32'd1);

    // Randomized traffic with shifting write/read biases
    for (int blk = 0; blk < 15; blk++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
            DATA_W'($urandom));
      end
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
